// File: rtl/regfile_dump_pkg.sv
// Shared constants and types for the register-file dump sequencer.
// REGFILE_DUMP_SKIP_ZERO_EN: when defined, the dump skips hard-wired register 0.
package regfile_dump_pkg;

   localparam int NUM_REGS_DEF = 32;
   localparam int DATA_W_DEF   = 32;
   localparam int IDX_W        = 5;

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [2:0]       state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_FREEZE = 3'd1;
   localparam state_t ST_READ   = 3'd2;
   localparam state_t ST_SEND   = 3'd3;
   localparam state_t ST_DONE   = 3'd4;

   localparam idx_t IDX_STEP = 5'd1;

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
   localparam idx_t FIRST_IDX = 5'd1;
`else
   localparam idx_t FIRST_IDX = 5'd0;
`endif

endpackage

// File: rtl/regfile_dump_if.sv
// Dump beat stream: valid/ready handshake carrying register index and value.
interface regfile_dump_if
   import regfile_dump_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);
   logic              valid;
   logic              ready;
   logic [IDX_W-1:0]  index;
   logic [DATA_W-1:0] data;

   modport master (output valid, output index, output data, input ready);
   modport slave  (input valid, input index, input data, output ready);
endinterface

// File: rtl/regfile_dump.sv
// Freezes the processor and streams every architectural register out over a
// valid/ready beat interface, one register per beat with a read bubble between.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | processor running, waiting for start
// ST_FREEZE | processor frozen, one settle cycle before the first read
// ST_READ   | rf_raddr presented, capture rf_rdata into the beat
// ST_SEND   | beat valid, hold until the sink accepts it
// ST_DONE   | one-cycle completion pulse, then release the processor
module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int DATA_W   = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   output logic                pc_enable,
   output logic [IDX_W-1:0]    rf_raddr,
   input  logic [DATA_W-1:0]   rf_rdata,
   regfile_dump_if.master      dump,
   output logic                busy,
   output logic                done
);

   localparam idx_t LAST_IDX = idx_t'(NUM_REGS - 1);

   state_t state;
   logic   abortable;

   assign abortable = (state == ST_FREEZE) || (state == ST_READ) || (state == ST_SEND);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         pc_enable  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         dump.valid <= 1'b0;
         dump.index <= '0;
         dump.data  <= '0;
         rf_raddr   <= '0;
      end else begin
         done <= 1'b0;
         // A beat accepted in the abort cycle is already gone; just drop back to idle.
         if (abort && abortable) begin
            state      <= ST_IDLE;
            pc_enable  <= 1'b1;
            busy       <= 1'b0;
            dump.valid <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     state     <= ST_FREEZE;
                     pc_enable <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
               ST_FREEZE: begin
                  state    <= ST_READ;
                  rf_raddr <= FIRST_IDX;
               end
               ST_READ: begin
                  state      <= ST_SEND;
                  dump.data  <= rf_rdata;
                  dump.index <= rf_raddr;
                  dump.valid <= 1'b1;
               end
               ST_SEND: begin
                  if (dump.ready) begin
                     dump.valid <= 1'b0;
                     if (rf_raddr == LAST_IDX) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                     end else begin
                        state    <= ST_READ;
                        rf_raddr <= rf_raddr + IDX_STEP;
                     end
                  end
               end
               ST_DONE: begin
                  state     <= ST_IDLE;
                  pc_enable <= 1'b1;
                  busy      <= 1'b0;
               end
               default: begin
                  state      <= ST_IDLE;
                  pc_enable  <= 1'b1;
                  busy       <= 1'b0;
                  dump.valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter: NUM_REGS, 32, number of architectural registers walked; index width is 5 bits.
REQ-002 Parameter: DATA_W, 32, register data width.
REQ-003 Port: clk  in  1  single system clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: start  in  1  request a full register-file dump; sampled only in IDLE.
REQ-006 Port: abort  in  1  terminate a dump in progress.
REQ-007 Port: pc_enable  out  1  processor PC enable; 0 freezes the processor for the dump.
REQ-008 Port: rf_raddr  out  5  register-file read address.
REQ-009 Port: rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr.
REQ-010 Port: dump_valid  out  1  beat valid.
REQ-011 Port: dump_ready  in  1  sink ready; a beat transfers on a cycle with valid and ready both high.
REQ-012 Port: dump_index  out  5  register number of the current beat.
REQ-013 Port: dump_data  out  DATA_W  register value of the current beat.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: done  out  1  one-cycle pulse on normal completion.

Function
REQ-016 The FSM SHALL have the states IDLE, FREEZE, READ, SEND and DONE; all outputs are registered.
REQ-017 IDLE: start=1 -> FREEZE; pc_enable=0 and busy=1 from the next cycle.
REQ-018 FREEZE lasts exactly one cycle, then -> READ with rf_raddr = first index.
REQ-019 READ lasts one cycle: capture rf_rdata into dump_data and rf_raddr into dump_index, then -> SEND with dump_valid=1.
REQ-020 Latency from the start edge to the first dump_valid is 3 cycles.
REQ-021 SEND: dump_valid, dump_index and dump_data hold stable until dump_ready=1.
REQ-022 SEND, on transfer: if index = NUM_REGS-1 -> DONE, else index+1 -> READ (one idle bubble between beats).
REQ-023 DONE lasts one cycle: done=1, dump_valid=0, pc_enable=1 on the next cycle, then -> IDLE.
REQ-024 start while busy is ignored; start coincident with DONE is ignored.
REQ-025 abort=1 in FREEZE, READ or SEND -> IDLE next cycle, with no done pulse and pc_enable=1 restored.
REQ-026 abort and a transfer in the same cycle: the beat counts as transferred, then the abort applies.
REQ-027 The index counter does not wrap: the beat at NUM_REGS-1 is always the last.

Reset
REQ-028 reset SHALL force the FSM to IDLE immediately, independent of clk, including mid-dump.
REQ-029 Reset values: pc_enable=1, busy=0, done=0, dump_valid=0, rf_raddr=0, dump_index=0, dump_data=0.

Configuration
REQ-030 Macro REGFILE_DUMP_SKIP_ZERO_EN defined: the dump starts at index 1 and emits NUM_REGS-1 beats (register 0 is hard-wired zero and omitted).
REQ-031 Macro undefined: the dump starts at index 0 and emits NUM_REGS beats.

Structure
REQ-032 The FSM state encodings, NUM_REGS and DATA_W defaults SHALL live in the shared CPU package/header; the block contains no other constants.
REQ-033 Implementation is a single module, one FSM plus a 5-bit index counter; no sub-module.

Verification
REQ-034 rf[i]=i*0x11111111 (truncated to 32 bits), dump_ready tied to 1, start pulse at cycle 0 -> beats with index 0..31 and matching data; first valid at cycle 3; done at the last beat+1; pc_enable=0 throughout.
REQ-035 dump_ready low for 4 cycles on beat 5 -> index 5 and data 0x55555555 held stable for those 4 cycles; no beat lost or duplicated.
REQ-036 abort asserted during beat 10 with ready=0 -> IDLE next cycle, pc_enable=1, done never asserted, no beat 11.
REQ-037 reset asserted between clock edges during SEND -> outputs at reset values immediately; a subsequent start gives a full dump from the first index.
REQ-038 With REGFILE_DUMP_SKIP_ZERO_EN defined -> 31 beats, first index 1, last index 31; start pulses during the dump are ignored.
